// File: rtl/apb_pkg.sv
// apb_pkg
//   Shared types for the APB requester: FSM state encoding, default bus
//   widths and a default-width command record.
package apb_pkg;

  localparam int unsigned APB_A_WIDTH = 8;
  localparam int unsigned APB_D_WIDTH = 8;
  localparam int unsigned APB_CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                   write;
    logic [APB_A_WIDTH-1:0] addr;
    logic [APB_D_WIDTH-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer
//   Wait-state counter for the ACCESS watchdog.
//   Ports:
//     p_clk, p_rst : clock, asynchronous active-high reset
//     clear        : zero the count (held while in SETUP)
//     incr         : count one stalled ACCESS cycle
//     limit        : abort threshold (TIMEOUT)
//     expired      : count has reached limit-1
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int unsigned CW = APB_CNT_WIDTH
) (
  input  logic          p_clk,
  input  logic          p_rst,
  input  logic          clear,
  input  logic          incr,
  input  logic [CW-1:0] limit,
  output logic          expired
);

  logic [CW-1:0] count_r;

  // Wait-cycle counter: clear has priority over increment.
  always_ff @(posedge p_clk or posedge p_rst) begin
    if (p_rst) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (incr) begin
      count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == (limit - {{(CW-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   Requester end of an APB link. Accepts single read/write commands on a
//   valid/ready port, runs them as SETUP/ACCESS transfers, honours p_ready
//   wait states and returns a one-cycle response pulse.
//   Optional watchdog: define APB_MASTER_TIMEOUT_EN to abort transfers that
//   stall in ACCESS for TIMEOUT cycles; otherwise rsp_timeout is tied low.
//   Ports:
//     p_clk, p_rst                  : clock, asynchronous active-high reset
//     cmd_valid/cmd_ready           : command handshake (cmd_ready is comb)
//     cmd_write/cmd_addr/cmd_wdata  : command payload
//     rsp_valid/rsp_rdata/rsp_err/rsp_timeout : completion response
//     p_sel/p_enable/p_write/p_addr/wr_data   : APB request
//     rd_data/p_ready/p_slverr      : APB slave response
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned A_WIDTH = APB_A_WIDTH,
  parameter int unsigned D_WIDTH = APB_D_WIDTH,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               p_clk,
  input  logic               p_rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [A_WIDTH-1:0] cmd_addr,
  input  logic [D_WIDTH-1:0] cmd_wdata,
  output logic               rsp_valid,
  output logic [D_WIDTH-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               rsp_timeout,
  output logic               p_sel,
  output logic               p_enable,
  output logic               p_write,
  output logic [A_WIDTH-1:0] p_addr,
  output logic [D_WIDTH-1:0] wr_data,
  input  logic [D_WIDTH-1:0] rd_data,
  input  logic               p_ready,
  input  logic               p_slverr
);

  apb_state_e         state_r;
  apb_state_e         state_s;
  logic               accept_s;
  logic               complete_s;
  logic               abort_s;
  logic               p_sel_r;
  logic               p_enable_r;
  logic               p_write_r;
  logic [A_WIDTH-1:0] p_addr_r;
  logic [D_WIDTH-1:0] wr_data_r;
  logic               rsp_valid_r;
  logic [D_WIDTH-1:0] rsp_rdata_r;
  logic               rsp_err_r;
  logic               rsp_timeout_r;

  // In ACCESS, p_sel and p_enable are both high, so p_ready alone qualifies
  // completion and p_slverr sampling.
  assign complete_s = (state_r == ACCESS) && p_ready;
  assign accept_s   = cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  logic timer_expired_s;

  apb_wait_timer #(
    .CW(APB_CNT_WIDTH)
  ) u_wait_timer (
    .p_clk   (p_clk),
    .p_rst   (p_rst),
    .clear   (state_r == SETUP),
    .incr    ((state_r == ACCESS) && !p_ready),
    .limit   (APB_CNT_WIDTH'(TIMEOUT)),
    .expired (timer_expired_s)
  );

  // A late p_ready on the limit cycle wins: abort needs p_ready low.
  assign abort_s = (state_r == ACCESS) && !p_ready && timer_expired_s;
`else
  logic [APB_CNT_WIDTH-1:0] unused_timeout_s;

  assign unused_timeout_s = APB_CNT_WIDTH'(TIMEOUT);
  assign abort_s          = 1'b0;
`endif

  // Command acceptance: idle, or the completing ACCESS cycle (back-to-back).
  always_comb begin
    cmd_ready = 1'b0;
    case (state_r)
      IDLE:    cmd_ready = 1'b1;
      ACCESS:  cmd_ready = p_ready;
      SETUP:   cmd_ready = 1'b0;
      default: cmd_ready = 1'b0;
    endcase
  end

  // Next-state logic for the SETUP/ACCESS sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = SETUP;
        else          state_s = IDLE;
      end
      SETUP: state_s = ACCESS;
      ACCESS: begin
        if (complete_s)   state_s = accept_s ? SETUP : IDLE;
        else if (abort_s) state_s = IDLE;
        else              state_s = ACCESS;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register with APB strobes registered from the next state.
  always_ff @(posedge p_clk or posedge p_rst) begin
    if (p_rst) begin
      state_r    <= IDLE;
      p_sel_r    <= 1'b0;
      p_enable_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      p_sel_r    <= (state_s != IDLE);
      p_enable_r <= (state_s == ACCESS);
    end
  end

  // Request slice: loaded on accept, held through the transfer and in IDLE.
  always_ff @(posedge p_clk or posedge p_rst) begin
    if (p_rst) begin
      p_write_r <= 1'b0;
      p_addr_r  <= {A_WIDTH{1'b0}};
      wr_data_r <= {D_WIDTH{1'b0}};
    end else if (accept_s) begin
      p_write_r <= cmd_write;
      p_addr_r  <= cmd_addr;
      wr_data_r <= cmd_wdata;
    end else begin
      p_write_r <= p_write_r;
      p_addr_r  <= p_addr_r;
      wr_data_r <= wr_data_r;
    end
  end

  // Response slice: one-cycle valid, payload held between completions.
  always_ff @(posedge p_clk or posedge p_rst) begin
    if (p_rst) begin
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= {D_WIDTH{1'b0}};
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
    end else if (complete_s) begin
      rsp_valid_r   <= 1'b1;
      rsp_rdata_r   <= p_write_r ? {D_WIDTH{1'b0}} : rd_data;
      rsp_err_r     <= p_slverr;
      rsp_timeout_r <= 1'b0;
    end else if (abort_s) begin
      rsp_valid_r   <= 1'b1;
      rsp_rdata_r   <= {D_WIDTH{1'b0}};
      rsp_err_r     <= 1'b1;
      rsp_timeout_r <= 1'b1;
    end else begin
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= rsp_rdata_r;
      rsp_err_r     <= rsp_err_r;
      rsp_timeout_r <= rsp_timeout_r;
    end
  end

  assign p_sel     = p_sel_r;
  assign p_enable  = p_enable_r;
  assign p_write   = p_write_r;
  assign p_addr    = p_addr_r;
  assign wr_data   = wr_data_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
`ifdef APB_MASTER_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_r;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule
